mem_port_arbiter: RTL and testbench

- Shares one single-ported backing memory between the CPU's instruction port (imem_*) and data port (dmem_*).
- Sits between cpu and a single-port memory model / future cache, replacing the dual-port memory.
- Accepts one outstanding request per side and serializes them to memory with data-first priority and a starvation cap for fetch.
- Routes each memory response back to the side that owns it.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter_req_slot.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which CPU side owns the memory transaction
//   mem_req_t   : one captured request (address, masks, store data)
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] rmask;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One memory port: requester drives addr/masks/wdata, responder drives
// rdata/resp.
// Handshake: a request is a single cycle with rmask or wmask nonzero; the
// responder answers later with a single-cycle resp, rdata valid with it.
// There is no backpressure; a requester keeps at most one request open.
//   master : requester view (drives addr, rmask, wmask, wdata)
//   slave  : responder view (drives rdata, resp)
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              resp;

    modport master (
        output addr, rmask, wmask, wdata,
        input  rdata, resp
    );

    modport slave (
        input  addr, rmask, wmask, wdata,
        output rdata, resp
    );

endinterface

// File: rtl/mem_port_arbiter_req_slot.sv
// req_slot: one-entry pending holder for a single CPU side.
//   clk, rst    : clock, synchronous active-high reset
//   i_req       : valid request this cycle
//   i_req_data  : request contents to capture
//   i_free      : the held request was answered this cycle
//   o_full      : a request is held
//   o_data      : held request
//   o_ovf       : request arrived while the slot was busy (dropped)
module req_slot
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_req,
    input  mem_req_t i_req_data,
    input  logic     i_free,
    output logic     o_full,
    output mem_req_t o_data,
    output logic     o_ovf
);

    logic     r_full;
    mem_req_t r_data;

    // A request landing in the same cycle as the answer to the previous one
    // replaces it instead of being treated as an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_req && (!r_full || i_free)) begin
            r_full <= 1'b1;
            r_data <= i_req_data;
        end else if (i_free) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_ovf  = i_req && r_full && !i_free;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the CPU fetch
// port and data port. One pending request per side, data side preferred,
// fetch granted after MAX_DSTREAK consecutive data grants while it waits.
//   clk, rst      : clock, synchronous active-high reset
//   imem          : fetch port (reads only; wmask/wdata ignored)
//   dmem          : data port (loads and stores)
//   mem           : backing memory port
//   proto_err     : sticky protocol-violation flag
//   o_dbg_state   : arbiter FSM state
//   o_dbg_streak  : consecutive data grants while fetch waited
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int MAX_DSTREAK = 4,
    localparam int STREAK_W    = $clog2(MAX_DSTREAK + 1)
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   imem,
    mem_port_arbiter_if.slave   dmem,
    mem_port_arbiter_if.master  mem,
    output logic                proto_err,
    output arb_state_t          o_dbg_state,
    output logic [STREAK_W-1:0] o_dbg_streak
);

    arb_state_t          r_state, w_next_state;
    grant_t              r_grant, w_pick;
    logic [STREAK_W-1:0] r_streak;
    mem_req_t            r_mem;
    logic [DATA_W-1:0]   r_i_rdata, r_d_rdata;
    logic                r_proto_err;

    logic     w_i_req, w_d_rd, w_d_wr, w_d_conflict, w_d_req;
    logic     w_i_full, w_d_full, w_i_ovf, w_d_ovf;
    logic     w_i_free, w_d_free, w_grant_now, w_stray_resp;
    mem_req_t w_i_new, w_d_new, w_i_data, w_d_data;
    logic [DATA_W-1:0] w_d_rdata_now;

    assign w_i_req      = |imem.rmask;
    assign w_d_rd       = |dmem.rmask;
    assign w_d_wr       = |dmem.wmask;
    assign w_d_conflict = w_d_rd && w_d_wr;
    assign w_d_req      = (w_d_rd || w_d_wr) && !w_d_conflict;

    assign w_i_new = '{addr: imem.addr, rmask: imem.rmask, wmask: '0, wdata: '0};
    assign w_d_new = '{addr: dmem.addr, rmask: dmem.rmask, wmask: dmem.wmask,
                       wdata: dmem.wdata};

    // The answer belongs to whichever side was granted; outside WAIT it has
    // no owner and only flags an error.
    assign w_i_free     = (r_state == WAIT) && mem.resp && (r_grant == GNT_I);
    assign w_d_free     = (r_state == WAIT) && mem.resp && (r_grant == GNT_D);
    assign w_stray_resp = mem.resp && (r_state != WAIT);

    req_slot u_i_slot (
        .clk        (clk),
        .rst        (rst),
        .i_req      (w_i_req),
        .i_req_data (w_i_new),
        .i_free     (w_i_free),
        .o_full     (w_i_full),
        .o_data     (w_i_data),
        .o_ovf      (w_i_ovf)
    );

    req_slot u_d_slot (
        .clk        (clk),
        .rst        (rst),
        .i_req      (w_d_req),
        .i_req_data (w_d_new),
        .i_free     (w_d_free),
        .o_full     (w_d_full),
        .o_data     (w_d_data),
        .o_ovf      (w_d_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pick       = GNT_I;
        w_grant_now  = 1'b0;
        if (w_d_full && !(w_i_full && r_streak == STREAK_W'(MAX_DSTREAK)))
            w_pick = GNT_D;
        case (r_state)
            IDLE: begin
                if (w_i_full || w_d_full) begin
                    w_next_state = ISSUE;
                    w_grant_now  = 1'b1;
                end
            end
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (mem.resp) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Stores return no data; the data side reads back zero for them.
    assign w_d_rdata_now = (|w_d_data.wmask) ? '0 : mem.rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= GNT_I;
            r_streak    <= '0;
            r_mem       <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_grant_now) begin
                r_grant <= w_pick;
                r_mem   <= (w_pick == GNT_D) ? w_d_data : w_i_data;
                // Only data grants that bypass a waiting fetch count.
                if (w_pick == GNT_D && w_i_full) begin
                    if (r_streak != STREAK_W'(MAX_DSTREAK))
                        r_streak <= r_streak + STREAK_W'(1);
                end else begin
                    r_streak <= '0;
                end
            end else if (r_state == ISSUE) begin
                // Masks are a one-cycle pulse; address and data stay put.
                r_mem.rmask <= '0;
                r_mem.wmask <= '0;
            end
            if (w_i_free) r_i_rdata <= mem.rdata;
            if (w_d_free) r_d_rdata <= w_d_rdata_now;
            if (w_i_ovf || w_d_ovf || w_d_conflict || w_stray_resp)
                r_proto_err <= 1'b1;
        end
    end

    assign mem.addr   = r_mem.addr;
    assign mem.rmask  = r_mem.rmask;
    assign mem.wmask  = r_mem.wmask;
    assign mem.wdata  = r_mem.wdata;

    assign imem.resp  = w_i_free;
    assign imem.rdata = w_i_free ? mem.rdata : r_i_rdata;
    assign dmem.resp  = w_d_free;
    assign dmem.rdata = w_d_free ? w_d_rdata_now : r_d_rdata;

    assign proto_err    = r_proto_err;
    assign o_dbg_state  = r_state;
    assign o_dbg_streak = r_streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs are driven and outputs sampled
// on the falling edge; the memory model reacts just after the rising edge.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if imem_bus ();
    mem_port_arbiter_if dmem_bus ();
    mem_port_arbiter_if mem_bus ();

    logic       proto_err;
    arb_state_t dbg_state;
    logic [2:0] dbg_streak;

    mem_port_arbiter #(.MAX_DSTREAK(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem_bus),
        .dmem         (dmem_bus),
        .mem          (mem_bus),
        .proto_err    (proto_err),
        .o_dbg_state  (dbg_state),
        .o_dbg_streak (dbg_streak)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- memory model ----------------
    logic        model_resp = 1'b0;
    logic [31:0] model_rdata = '0;
    logic        manual_resp = 1'b0;
    logic        mem_auto = 1'b1;
    int          mem_lat = 3;
    int          mem_cnt = 0;
    logic [31:0] pend_addr = '0;
    mem_req_t    iss_q[$];
    logic [31:0] exp_q[$];

    assign mem_bus.resp  = model_resp | manual_resp;
    assign mem_bus.rdata = model_rdata;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h1ECEB000) return 32'h0000_0013;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    always begin
        @(posedge clk);
        #1;
        model_resp = 1'b0;
        if (rst) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0 && mem_auto) begin
                    model_resp  = 1'b1;
                    model_rdata = mem_model(pend_addr);
                end
            end
            if (mem_bus.rmask != '0 || mem_bus.wmask != '0) begin
                iss_q.push_back('{addr: mem_bus.addr, rmask: mem_bus.rmask,
                                  wmask: mem_bus.wmask, wdata: mem_bus.wdata});
                pend_addr = mem_bus.addr;
                mem_cnt   = mem_lat;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        imem_bus.addr = '0; imem_bus.rmask = '0; imem_bus.wmask = '0; imem_bus.wdata = '0;
        dmem_bus.addr = '0; dmem_bus.rmask = '0; dmem_bus.wmask = '0; dmem_bus.wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({mem_bus.rmask, mem_bus.wmask, mem_bus.addr, mem_bus.wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mem: rmask=%h wmask=%h addr=%h wdata=%h, required all 0",
                     mem_bus.rmask, mem_bus.wmask, mem_bus.addr, mem_bus.wdata);
        end
        checks++;
        if ({imem_bus.resp, dmem_bus.resp, imem_bus.rdata, dmem_bus.rdata, proto_err} !== '0) begin
            errors++;
            $display("FAIL reset_cpu: iresp=%b dresp=%b irdata=%h drdata=%h perr=%b, required 0",
                     imem_bus.resp, dmem_bus.resp, imem_bus.rdata, dmem_bus.rdata, proto_err);
        end
        checks++;
        if (dbg_state !== IDLE || dbg_streak !== 3'd0) begin
            errors++;
            $display("FAIL reset_fsm: state=%0d streak=%0d, required 0 0", dbg_state, dbg_streak);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        int c;
        logic seen_d;
        mem_lat = 3;
        iss_q.delete();
        imem_bus.addr = 32'h1ECEB000; imem_bus.rmask = 4'hF;
        tick();
        imem_bus.rmask = '0;
        checks++;
        if (mem_bus.rmask !== 4'h0) begin
            errors++;
            $display("FAIL fetch_early: mem_rmask=%h at t+1, required 0", mem_bus.rmask);
        end
        tick();
        checks++;
        if (mem_bus.rmask !== 4'hF || mem_bus.addr !== 32'h1ECEB000) begin
            errors++;
            $display("FAIL fetch_issue: mem_rmask=%h addr=%h at t+2, required F 1eceb000",
                     mem_bus.rmask, mem_bus.addr);
        end
        c = 0;
        seen_d = 1'b0;
        while (!imem_bus.resp && c < 20) begin
            tick();
            c++;
            if (dmem_bus.resp) seen_d = 1'b1;
        end
        checks++;
        if (!imem_bus.resp || c != 3 || imem_bus.rdata !== 32'h0000_0013) begin
            errors++;
            $display("FAIL fetch_resp: resp=%b after %0d cycles data=%h, required 1 after 3 data 00000013",
                     imem_bus.resp, c, imem_bus.rdata);
        end
        checks++;
        if (seen_d || dmem_bus.resp) begin
            errors++;
            $display("FAIL fetch_dresp: dmem_resp seen=1, required 0");
        end
        tick();
    endtask

    task automatic test_simultaneous();
        int c;
        int got_i, got_d;
        logic [31:0] i_data, d_data, i_hold;
        mem_lat = 2;
        iss_q.delete();
        exp_q.delete();
        exp_q.push_back(32'h1ECEC000);
        exp_q.push_back(32'h1ECEB004);
        imem_bus.addr = 32'h1ECEB004; imem_bus.rmask = 4'hF;
        dmem_bus.addr = 32'h1ECEC000; dmem_bus.rmask = 4'hF;
        got_i = 0; got_d = 0;
        i_data = '0; d_data = '0; i_hold = '0;
        c = 0;
        while (!(got_i > 0 && got_d > 0) && c < 40) begin
            tick();
            imem_bus.rmask = '0;
            dmem_bus.rmask = '0;
            c++;
            if (dmem_bus.resp) begin got_d++; d_data = dmem_bus.rdata; i_hold = imem_bus.rdata; end
            if (imem_bus.resp) begin got_i++; i_data = imem_bus.rdata; end
        end
        checks++;
        if (got_i != 1 || got_d != 1) begin
            errors++;
            $display("FAIL simul_resps: iresp=%0d dresp=%0d, required 1 1", got_i, got_d);
        end
        checks++;
        if (d_data !== 32'h44949A5A || i_data !== 32'h4494EA5E) begin
            errors++;
            $display("FAIL simul_data: drdata=%h irdata=%h, required 44949a5a 4494ea5e", d_data, i_data);
        end
        checks++;
        if (i_hold !== 32'h0000_0013) begin
            errors++;
            $display("FAIL simul_hold: imem_rdata=%h during dmem_resp, required 00000013", i_hold);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (iss_q.size() <= k || iss_q[k].addr !== exp_q[k]) begin
                errors++;
                $display("FAIL simul_order[%0d]: addr=%h, required %h", k,
                         (iss_q.size() > k) ? iss_q[k].addr : 32'hXXXXXXXX, exp_q[k]);
            end
        end
        tick();
    endtask

    task automatic test_store();
        int c;
        logic saw_rmask;
        mem_lat = 2;
        iss_q.delete();
        dmem_bus.addr = 32'h0000_0300; dmem_bus.wmask = 4'h3; dmem_bus.wdata = 32'hDEADBEEF;
        tick();
        dmem_bus.wmask = '0; dmem_bus.wdata = '0;
        saw_rmask = (mem_bus.rmask != '0);
        tick();
        checks++;
        if (mem_bus.wmask !== 4'h3 || mem_bus.wdata !== 32'hDEADBEEF || mem_bus.addr !== 32'h300) begin
            errors++;
            $display("FAIL store_issue: wmask=%h wdata=%h addr=%h, required 3 deadbeef 00000300",
                     mem_bus.wmask, mem_bus.wdata, mem_bus.addr);
        end
        if (mem_bus.rmask != '0) saw_rmask = 1'b1;
        tick();
        checks++;
        if (mem_bus.wmask !== 4'h0 || mem_bus.wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_pulse: wmask=%h wdata=%h next cycle, required 0 deadbeef",
                     mem_bus.wmask, mem_bus.wdata);
        end
        c = 0;
        while (!dmem_bus.resp && c < 20) begin
            if (mem_bus.rmask != '0) saw_rmask = 1'b1;
            tick();
            c++;
        end
        checks++;
        if (!dmem_bus.resp || dmem_bus.rdata !== 32'h0 || imem_bus.resp) begin
            errors++;
            $display("FAIL store_resp: dresp=%b drdata=%h iresp=%b, required 1 0 0",
                     dmem_bus.resp, dmem_bus.rdata, imem_bus.resp);
        end
        checks++;
        if (saw_rmask) begin
            errors++;
            $display("FAIL store_rmask: mem_rmask nonzero=1, required 0");
        end
        tick();
    endtask

    task automatic test_starvation();
        int n_st, d_cnt, i_cnt, c;
        logic [31:0] i_data;
        logic [2:0]  streak_at_i;
        mem_lat = 1;
        iss_q.delete();
        exp_q.delete();
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        exp_q.push_back(32'h108); exp_q.push_back(32'h10C);
        exp_q.push_back(32'h2000); exp_q.push_back(32'h110);
        imem_bus.addr = 32'h2000; imem_bus.rmask = 4'hF;
        dmem_bus.addr = 32'h100; dmem_bus.wmask = 4'hF; dmem_bus.wdata = 32'd0;
        n_st = 1; d_cnt = 0; i_cnt = 0; c = 0;
        i_data = '0; streak_at_i = 3'd7;
        while (!(d_cnt == 5 && i_cnt == 1) && c < 200) begin
            tick();
            c++;
            imem_bus.rmask = '0;
            dmem_bus.wmask = '0;
            if (dmem_bus.resp) begin
                d_cnt++;
                if (n_st < 5) begin
                    dmem_bus.addr  = 32'h100 + 32'(4 * n_st);
                    dmem_bus.wmask = 4'hF;
                    dmem_bus.wdata = 32'(n_st);
                    n_st++;
                end
            end
            if (imem_bus.resp) begin
                i_cnt++;
                i_data = imem_bus.rdata;
                streak_at_i = dbg_streak;
            end
        end
        checks++;
        if (d_cnt != 5 || i_cnt != 1) begin
            errors++;
            $display("FAIL starve_count: dresp=%0d iresp=%0d, required 5 1", d_cnt, i_cnt);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (iss_q.size() <= k || iss_q[k].addr !== exp_q[k]) begin
                errors++;
                $display("FAIL starve_order[%0d]: addr=%h, required %h", k,
                         (iss_q.size() > k) ? iss_q[k].addr : 32'hXXXXXXXX, exp_q[k]);
            end
        end
        checks++;
        if (i_data !== 32'h5A5A7A5A || streak_at_i !== 3'd0) begin
            errors++;
            $display("FAIL starve_fetch: irdata=%h streak=%0d, required 5a5a7a5a 0", i_data, streak_at_i);
        end
        tick();
        checks++;
        if (dbg_streak !== 3'd0) begin
            errors++;
            $display("FAIL starve_streak_end: streak=%0d, required 0", dbg_streak);
        end
    endtask

    task automatic test_proto_errors();
        int c;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL perr_clean: proto_err=%b before error tests, required 0", proto_err);
        end
        mem_lat = 3;
        iss_q.delete();
        imem_bus.addr = 32'h400; imem_bus.rmask = 4'hF;
        tick();
        imem_bus.rmask = '0;
        tick();
        imem_bus.addr = 32'h404; imem_bus.rmask = 4'hF;
        tick();
        imem_bus.rmask = '0;
        c = 0;
        while (!imem_bus.resp && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (!imem_bus.resp || imem_bus.rdata !== 32'h5A5A5E5A) begin
            errors++;
            $display("FAIL perr_dup_resp: iresp=%b irdata=%h, required 1 5a5a5e5a", imem_bus.resp, imem_bus.rdata);
        end
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (proto_err !== 1'b1 || iss_q.size() != 1) begin
            errors++;
            $display("FAIL perr_dup: proto_err=%b fetches=%0d, required 1 1", proto_err, iss_q.size());
        end

        do_reset();
        iss_q.delete();
        dmem_bus.addr = 32'h600; dmem_bus.rmask = 4'hF; dmem_bus.wmask = 4'hF;
        tick();
        dmem_bus.rmask = '0; dmem_bus.wmask = '0;
        c = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (dmem_bus.resp || imem_bus.resp) c++;
        end
        checks++;
        if (proto_err !== 1'b1 || iss_q.size() != 0 || c != 0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL perr_rw: proto_err=%b requests=%0d resps=%0d state=%0d, required 1 0 0 0",
                     proto_err, iss_q.size(), c, dbg_state);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_wait();
        int c;
        mem_auto = 1'b0;
        mem_lat = 3;
        iss_q.delete();
        imem_bus.addr = 32'h500; imem_bus.rmask = 4'hF;
        tick();
        imem_bus.rmask = '0;
        c = 0;
        while (iss_q.size() == 0 && c < 20) begin
            tick();
            c++;
        end
        tick();
        checks++;
        if (iss_q.size() != 1 || dbg_state !== WAIT) begin
            errors++;
            $display("FAIL rstw_wait: requests=%0d state=%0d, required 1 2", iss_q.size(), dbg_state);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dbg_state !== IDLE || proto_err !== 1'b0 || mem_bus.rmask !== 4'h0) begin
            errors++;
            $display("FAIL rstw_after: state=%0d proto_err=%b rmask=%h, required 0 0 0",
                     dbg_state, proto_err, mem_bus.rmask);
        end
        manual_resp = 1'b1;
        #1;
        checks++;
        if (imem_bus.resp !== 1'b0 || dmem_bus.resp !== 1'b0) begin
            errors++;
            $display("FAIL rstw_stale: iresp=%b dresp=%b on stale mem_resp, required 0 0",
                     imem_bus.resp, dmem_bus.resp);
        end
        tick();
        manual_resp = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL rstw_perr: proto_err=%b state=%0d, required 1 0", proto_err, dbg_state);
        end
        mem_auto = 1'b1;
        mem_lat = 2;
        iss_q.delete();
        imem_bus.addr = 32'h1ECEB000; imem_bus.rmask = 4'hF;
        tick();
        imem_bus.rmask = '0;
        c = 0;
        while (!imem_bus.resp && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (!imem_bus.resp || imem_bus.rdata !== 32'h13 || iss_q.size() != 1) begin
            errors++;
            $display("FAIL rstw_fresh: iresp=%b irdata=%h requests=%0d, required 1 00000013 1",
                     imem_bus.resp, imem_bus.rdata, iss_q.size());
        end
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_starvation();
        test_proto_errors();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
